// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared types and constants for the decode-stage issue/hazard controller.
package decode_hazard_ctrl_pkg;

    localparam int unsigned REG_ID_W = 6;
    localparam int unsigned CNT_W    = 3;

    typedef logic [REG_ID_W-1:0] reg_id_t;

    localparam reg_id_t REG_ZERO = '0;

    typedef struct packed {
        logic    valid;
        reg_id_t rd;
    } sb_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } hz_state_t;

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Decode/execute/writeback signals seen by the hazard controller.
interface decode_hazard_ctrl_if;
    import decode_hazard_ctrl_pkg::*;

    logic    dec_valid;
    reg_id_t dec_rs1;
    reg_id_t dec_rs2;
    reg_id_t dec_rd;
    logic    dec_uses_rs1;
    logic    dec_uses_rs2;
    logic    dec_writes_rd;
    logic    ex_busy;
    logic    redirect;
    logic    wb_write_en;
    reg_id_t wb_write_id;
    logic    issue;
    logic    stall_fetch;
    logic    stall_decode;
    logic    flush_decode;
    logic    sb_error;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd,
        output dec_uses_rs1, dec_uses_rs2, dec_writes_rd,
        output ex_busy, redirect, wb_write_en, wb_write_id,
        input  issue, stall_fetch, stall_decode, flush_decode, sb_error
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd,
        input  dec_uses_rs1, dec_uses_rs2, dec_writes_rd,
        input  ex_busy, redirect, wb_write_en, wb_write_id,
        output issue, stall_fetch, stall_decode, flush_decode, sb_error
    );

endinterface

// File: rtl/decode_hazard_ctrl_hazard_scoreboard.sv
// In-flight destination scoreboard: stage shift register, RAW match and
// writeback consistency check.
module decode_hazard_ctrl_hazard_scoreboard
    import decode_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      ex_busy,
    input  sb_entry_t new_entry,
    input  logic      dec_valid,
    input  reg_id_t   dec_rs1,
    input  reg_id_t   dec_rs2,
    input  logic      dec_uses_rs1,
    input  logic      dec_uses_rs2,
    input  logic      wb_write_en,
    input  reg_id_t   wb_write_id,
    output logic      haz_c,
    output logic      sb_error
);

    localparam int unsigned CHECK = DEPTH - WB_BYPASS;

    sb_entry_t [DEPTH-1:0] entry_q;
    logic [CHECK-1:0]      hit1;
    logic [CHECK-1:0]      hit2;
    logic                  match1;
    logic                  match2;
    logic                  wb_bad_c;
    sb_entry_t             wb_entry;

    // Entries advance one stage per edge unless execute is frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_q <= '0;
        end else if (!ex_busy) begin
            entry_q <= {entry_q[DEPTH-2:0], new_entry};
        end
    end

    for (genvar g = 0; g < CHECK; g++) begin : g_hit
        assign hit1[g] = entry_q[g].valid && (entry_q[g].rd == dec_rs1);
        assign hit2[g] = entry_q[g].valid && (entry_q[g].rd == dec_rs2);
    end

    assign match1 = (dec_rs1 != REG_ZERO) && (|hit1);
    assign match2 = (dec_rs2 != REG_ZERO) && (|hit2);
    assign haz_c  = dec_valid && ((dec_uses_rs1 && match1) || (dec_uses_rs2 && match2));

    // The oldest entry must line up exactly with the register file write.
    assign wb_entry = entry_q[DEPTH-1];
    assign wb_bad_c = (wb_entry.valid && (!wb_write_en || (wb_write_id != wb_entry.rd)))
                   || (wb_write_en && !wb_entry.valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_error <= 1'b0;
        end else if (!ex_busy && wb_bad_c) begin
            sb_error <= 1'b1;
        end
    end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode issue controller: RAW stall, multi-cycle freeze and redirect flush
// sequencing for the fetch/decode pipeline registers.
module decode_hazard_ctrl
    import decode_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH        = 3,
    parameter int unsigned WB_BYPASS    = 1,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic                 clk,
    input logic                 reset_n,
    decode_hazard_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    hz_state_t        state_q;
    hz_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             haz_c;
    logic             issue_c;
    logic             stall_c;
    logic             flush_c;
    sb_entry_t        new_entry;
    logic             sb_error;

    assign new_entry.valid = issue_c && bus.dec_writes_rd && (bus.dec_rd != REG_ZERO);
    assign new_entry.rd    = bus.dec_rd;

    decode_hazard_ctrl_hazard_scoreboard #(
        .DEPTH     (DEPTH),
        .WB_BYPASS (WB_BYPASS)
    ) u_sb (
        .clk          (clk),
        .reset_n      (reset_n),
        .ex_busy      (bus.ex_busy),
        .new_entry    (new_entry),
        .dec_valid    (bus.dec_valid),
        .dec_rs1      (bus.dec_rs1),
        .dec_rs2      (bus.dec_rs2),
        .dec_uses_rs1 (bus.dec_uses_rs1),
        .dec_uses_rs2 (bus.dec_uses_rs2),
        .wb_write_en  (bus.wb_write_en),
        .wb_write_id  (bus.wb_write_id),
        .haz_c        (haz_c),
        .sb_error     (sb_error)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Redirect outranks the execute freeze, which outranks the RAW hazard.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue_c = 1'b0;
        stall_c = 1'b0;
        flush_c = 1'b0;
        case (state_q)
            RUN: begin
                flush_c = bus.redirect;
                issue_c = bus.dec_valid && !haz_c && !bus.ex_busy && !bus.redirect;
                stall_c = (haz_c || bus.ex_busy) && !bus.redirect;
                if (bus.redirect) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_LOAD;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                if (bus.redirect) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Pipeline controls are forced low the moment reset is asserted.
    assign bus.issue        = issue_c && reset_n;
    assign bus.stall_fetch  = stall_c && reset_n;
    assign bus.stall_decode = stall_c && reset_n;
    assign bus.flush_decode = flush_c && reset_n;
    assign bus.sb_error     = sb_error;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: per-cycle model compare plus
// directed scenarios with literal expectations.
module tb_decode_hazard_ctrl;
    import decode_hazard_ctrl_pkg::*;

    localparam int DEPTH        = 3;
    localparam int WB_BYPASS    = 1;
    localparam int FLUSH_CYCLES = 2;
    localparam int HAZ_STAGES   = DEPTH - WB_BYPASS;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    decode_hazard_ctrl_if bus ();

    decode_hazard_ctrl #(
        .DEPTH        (DEPTH),
        .WB_BYPASS    (WB_BYPASS),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each producer remembers the advance count at issue; its stage is
    // the number of non-frozen edges since then.
    typedef struct {
        int rd;
        int adv0;
    } prod_t;

    prod_t prods[$];
    int    adv = 0;
    int    flush_left = 0;
    bit    err_exp = 1'b0;
    bit    force_wb = 1'b0;
    int    force_id = 0;

    function automatic int stage_of(prod_t p);
        return adv - p.adv0 - 1;
    endfunction

    function automatic bit in_window(int r);
        if (r == 0) return 1'b0;
        foreach (prods[k])
            if (stage_of(prods[k]) < HAZ_STAGES && prods[k].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void wb_due(output bit v, output int rd);
        v = 1'b0;
        rd = 0;
        foreach (prods[k])
            if (stage_of(prods[k]) == DEPTH - 1) begin
                v = 1'b1;
                rd = prods[k].rd;
            end
    endfunction

    always @(negedge clk) begin
        bit haz;
        bit in_flush;
        bit e_issue;
        bit e_stall;
        bit e_flush;
        bit wv;
        bit wbad;
        int wrd;
        if (!reset_n) begin
            chk("rst_issue", bus.issue, 1'b0);
            chk("rst_stall_fetch", bus.stall_fetch, 1'b0);
            chk("rst_stall_decode", bus.stall_decode, 1'b0);
            chk("rst_flush", bus.flush_decode, 1'b0);
            chk("rst_sb_error", bus.sb_error, 1'b0);
            prods.delete();
            adv = 0;
            flush_left = 0;
            err_exp = 1'b0;
        end else begin
            haz = bus.dec_valid && ((bus.dec_uses_rs1 && in_window(int'(bus.dec_rs1)))
                               || (bus.dec_uses_rs2 && in_window(int'(bus.dec_rs2))));
            in_flush = flush_left > 0;
            e_flush = bus.redirect || in_flush;
            e_issue = !in_flush && !bus.redirect && !bus.ex_busy && bus.dec_valid && !haz;
            e_stall = !in_flush && !bus.redirect && (haz || bus.ex_busy);
            chk("issue", bus.issue, e_issue);
            chk("stall_fetch", bus.stall_fetch, e_stall);
            chk("stall_decode", bus.stall_decode, e_stall);
            chk("flush_decode", bus.flush_decode, e_flush);
            chk("sb_error", bus.sb_error, err_exp);
            if (!bus.ex_busy) begin
                wb_due(wv, wrd);
                wbad = wv ? (!bus.wb_write_en || int'(bus.wb_write_id) != wrd) : bus.wb_write_en;
                if (wbad) err_exp = 1'b1;
            end
            flush_left = bus.redirect ? FLUSH_CYCLES : (in_flush ? flush_left - 1 : 0);
            if (!bus.ex_busy) begin
                if (e_issue && bus.dec_writes_rd && bus.dec_rd != '0)
                    prods.push_back('{rd: int'(bus.dec_rd), adv0: adv});
                adv++;
                for (int k = prods.size() - 1; k >= 0; k--)
                    if (stage_of(prods[k]) >= DEPTH) prods.delete(k);
            end
        end
    end

    // Applies one cycle of decode inputs; writeback follows the model unless forced.
    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit w, input bit busy, input bit redir);
        bit wv;
        int wrd;
        @(posedge clk);
        #1;
        bus.dec_valid     = v;
        bus.dec_rs1       = REG_ID_W'(rs1);
        bus.dec_uses_rs1  = u1;
        bus.dec_rs2       = REG_ID_W'(rs2);
        bus.dec_uses_rs2  = u2;
        bus.dec_rd        = REG_ID_W'(rd);
        bus.dec_writes_rd = w;
        bus.ex_busy       = busy;
        bus.redirect      = redir;
        wb_due(wv, wrd);
        if (force_wb) begin
            bus.wb_write_en = 1'b1;
            bus.wb_write_id = REG_ID_W'(force_id);
        end else begin
            bus.wb_write_en = wv;
            bus.wb_write_id = wv ? REG_ID_W'(wrd) : '0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.dec_valid = 0; bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rd = '0;
        bus.dec_uses_rs1 = 0; bus.dec_uses_rs2 = 0; bus.dec_writes_rd = 0;
        bus.ex_busy = 0; bus.redirect = 0; bus.wb_write_en = 0; bus.wb_write_id = '0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        idle(1);

        // Back-to-back dependency on r5
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0);
        chk("b2b_prod_issue", bus.issue, 1'b1);
        drive(1, 5, 1, 2, 1, 6, 1, 0, 0);
        chk("b2b_stall1_issue", bus.issue, 1'b0);
        chk("b2b_stall1_fetch", bus.stall_fetch, 1'b1);
        drive(1, 5, 1, 2, 1, 6, 1, 0, 0);
        chk("b2b_stall2_decode", bus.stall_decode, 1'b1);
        drive(1, 5, 1, 2, 1, 6, 1, 0, 0);
        chk("b2b_issue3", bus.issue, 1'b1);
        chk("b2b_wb_en", bus.wb_write_en, 1'b1);
        idle(4);
        chk("b2b_no_sb_error", bus.sb_error, 1'b0);

        // x0 never hazards; unused rs2 ignored
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("x0_no_stall", bus.issue, 1'b1);
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
        drive(1, 1, 1, 7, 0, 0, 0, 0, 0);
        chk("unused_rs2_issue", bus.issue, 1'b1);
        chk("unused_rs2_stall", bus.stall_fetch, 1'b0);
        idle(4);

        // Redirect flush sequence, then reload during FLUSH
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("redir_flush", bus.flush_decode, 1'b1);
        chk("redir_issue", bus.issue, 1'b0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush1", bus.flush_decode, 1'b1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush2", bus.flush_decode, 1'b1);
        chk("flush2_issue", bus.issue, 1'b0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("resume_issue", bus.issue, 1'b1);
        chk("resume_flush", bus.flush_decode, 1'b0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("reload_flush", bus.flush_decode, 1'b1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reload_flush1", bus.flush_decode, 1'b1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reload_flush2", bus.flush_decode, 1'b1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reload_resume", bus.issue, 1'b1);
        idle(2);

        // ex_busy freezes the scoreboard with r3 in execute
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        chk("busy_prod_issue", bus.issue, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 1, 0, 0, 0, 0, 1, 0);
            chk("busy_stall", bus.stall_fetch, 1'b1);
        end
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("busy_haz1", bus.stall_decode, 1'b1);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("busy_haz2", bus.issue, 1'b0);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("busy_haz_issue", bus.issue, 1'b1);
        idle(4);
        chk("busy_no_sb_error", bus.sb_error, 1'b0);

        // Writeback id disagrees with scoreboard
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0);
        idle(2);
        force_wb = 1'b1;
        force_id = 10;
        idle(1);
        chk("mm_before_edge", bus.sb_error, 1'b0);
        force_wb = 1'b0;
        idle(1);
        chk("mm_set", bus.sb_error, 1'b1);
        idle(3);
        chk("mm_sticky", bus.sb_error, 1'b1);

        // Async reset in the middle of a hazard stall
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_stall", bus.stall_fetch, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_issue", bus.issue, 1'b0);
        chk("arst_stall_fetch", bus.stall_fetch, 1'b0);
        chk("arst_stall_decode", bus.stall_decode, 1'b0);
        chk("arst_flush", bus.flush_decode, 1'b0);
        chk("arst_sb_error", bus.sb_error, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_issue", bus.issue, 1'b1);
        chk("post_rst_stall", bus.stall_fetch, 1'b0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
Issue controller for the decode stage. It holds a per-stage scoreboard of destination registers for instructions in flight between decode and writeback. It detects read-after-write hazards against the register file read ports and freezes the front end on multi-cycle execute operations. It sequences the flush after a taken branch or jump redirect, and drives stall, flush and bubble controls into the fetch/decode pipeline registers.

Parameters:
REG_ID_W, 6, width of register ids (matches the register file write_id).
DEPTH, 3, in-flight stages tracked after decode: 0 = execute, 1 = memory, 2 = writeback.
WB_BYPASS, 1, 1 = register file writes through in the same cycle, so the writeback stage is excluded from the hazard check.
FLUSH_CYCLES, 2, cycles that decode input is squashed after a redirect (range 1..7).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
dec_valid  in  1  decode holds a valid instruction
dec_rs1  in  REG_ID_W  source 1 id
dec_rs2  in  REG_ID_W  source 2 id
dec_rd  in  REG_ID_W  destination id
dec_uses_rs1  in  1  instruction reads rs1
dec_uses_rs2  in  1  instruction reads rs2
dec_writes_rd  in  1  instruction writes rd
ex_busy  in  1  execute is running a multi-cycle operation; pipeline frozen
redirect  in  1  taken branch/jump resolved in execute (single-cycle pulse)
wb_write_en  in  1  register file write enable
wb_write_id  in  REG_ID_W  register file write id
issue  out  1  decode instruction advances to execute this cycle
stall_fetch  out  1  hold PC and fetch register
stall_decode  out  1  hold decode register
flush_decode  out  1  replace decode register with NOP at next edge
sb_error  out  1  sticky: writeback disagrees with scoreboard

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous, active-low, on reset_n.
- Reset values: all scoreboard entries invalid, state RUN, flush counter 0, sb_error 0. All outputs are 0 during reset.
- Scoreboard: DEPTH entries of {valid, rd}.
  - A new entry is valid only if the instruction issued, dec_writes_rd=1 and dec_rd!=0.
- Shift rule:
  - ex_busy=0: each edge, entry[i+1] <= entry[i] and entry[0] <= the new entry, or invalid if no issue.
  - ex_busy=1: all entries hold.
- Hazard (combinational):
  - haz = dec_valid & ((dec_uses_rs1 & match(dec_rs1)) | (dec_uses_rs2 & match(dec_rs2))).
  - match(r) = r!=0 and some valid entry[i].rd==r, for i < DEPTH-WB_BYPASS.
  - Register id 0 never hazards.
- FSM states: RUN, FLUSH.
  - RUN -> FLUSH when redirect=1; the counter loads FLUSH_CYCLES-1.
  - FLUSH: flush_decode=1 and issue=0 each cycle. The counter decrements, and the FSM returns to RUN after the cycle in which counter==0.
  - redirect while in FLUSH reloads the counter.
- Outputs in RUN:
  - issue = dec_valid & !haz & !ex_busy & !redirect.
  - stall_fetch = stall_decode = (haz | ex_busy) & !redirect.
  - flush_decode = redirect.
- Outputs in FLUSH: stall_fetch=stall_decode=0, issue=0.
- Priority: reset > redirect > ex_busy > hazard.
- Redirect cycle:
  - The redirect cycle itself asserts flush_decode and issue=0.
  - The branch in execute is not squashed. Older entries keep their contents and shift normally.
  - redirect with ex_busy=1 still enters FLUSH, but the scoreboard holds.
- Writeback check, every edge:
  - entry[DEPTH-1] valid, and (wb_write_en=0 or wb_write_id != its rd) -> sb_error <= 1.
  - wb_write_en=1 with entry[DEPTH-1] invalid -> sb_error <= 1.
  - Checking is suppressed while ex_busy=1.
  - sb_error clears only on reset.
- Latency: decode to issue is 0 cycles when there is no hazard. A dependent instruction directly behind its producer stalls DEPTH-WB_BYPASS cycles (2 at defaults).

Decomposition:
- Shared package: typedef sb_entry_t {valid, rd}, typedef hz_state_t enum {RUN, FLUSH}, constant REG_ZERO.
- One natural sub-module: hazard_scoreboard, containing the entry shift register, match logic and writeback check.
- The FSM and output decode stay in decode_hazard_ctrl.

Test Plan:
- Back-to-back dependency: issue rd=5, then an instruction with rs1=5 -> issue=0 and stall_fetch=stall_decode=1 for 2 cycles, issue=1 on the 3rd; wb_write_en/id=5 arrives in the writeback cycle, sb_error stays 0.
- x0 and unused sources: producer rd=0, consumer rs1=0; then producer rd=7, consumer rs2=7 with dec_uses_rs2=0 -> no stall in either case.
- Redirect: redirect pulse with dec_valid=1 -> flush_decode=1 for 2 consecutive cycles, issue=0 throughout, issue resumes on the 3rd cycle; redirect again in the 2nd FLUSH cycle -> 2 more flush cycles.
- ex_busy for 4 cycles with rd=3 in execute -> scoreboard frozen, stalls asserted for 4 cycles, then the normal 2-cycle hazard on rs1=3 completes.
- Scoreboard mismatch: entry rd=9 reaches writeback with wb_write_id=10 -> sb_error=1 next edge and stays 1 until reset_n low.
- Async reset mid-stall: drive reset_n low between clock edges while a hazard stall is active -> all outputs and sb_error go 0 immediately; after release, an instruction with rs1=5 issues with no stall.
